// File: rtl/rf_pkg.sv
// Shared widths and slot payload type for the register-file writeback path.
package rf_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned AW       = $clog2(NUM_REGS);
  localparam int unsigned DW       = 32;
  localparam logic [AW-1:0] REG_ZERO = AW'(0);

  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot: accepts when empty or draining this cycle.
module rf_wb_slot
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          drain,
  output logic          ready_c,
  output logic          load_c,
  output slot_t         slot
);

  assign ready_c = !slot.full || drain;
  // Writes to register 0 are acknowledged but never stored.
  assign load_c  = valid && ready_c && (addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load_c) begin
      slot.full <= 1'b1;
      slot.addr <= addr;
      slot.data <= data;
    end else if (drain) begin
      slot.full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter driving the single registered RF write port.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          rf_RegWrite,
  output logic [AW-1:0] rf_RD_Address,
  output logic [DW-1:0] rf_RDdata,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          rs_pending,
  output logic          rt_pending
);

  slot_t      s0, s1;
  logic       load0_c, load1_c;
  logic [1:0] gnt_c;
  logic       rr_flip_c;
  logic       tie_q;   // both slots were loaded on the same edge
  logic       old1_q;  // slot 1 holds the older entry
  logic       rr_q;

  rf_wb_slot u_slot0 (
    .clk(clk), .rst(rst), .valid(req0_valid), .addr(req0_addr), .data(req0_data),
    .drain(gnt_c[0]), .ready_c(req0_ready), .load_c(load0_c), .slot(s0)
  );

  rf_wb_slot u_slot1 (
    .clk(clk), .rst(rst), .valid(req1_valid), .addr(req1_addr), .data(req1_data),
    .drain(gnt_c[1]), .ready_c(req1_ready), .load_c(load1_c), .slot(s1)
  );

  // Grant: age first; same-edge ties go to slot 0 on equal address, else round-robin.
  always_comb begin
    gnt_c     = 2'b00;
    rr_flip_c = 1'b0;
    unique case ({s1.full, s0.full})
      2'b01: gnt_c = 2'b01;
      2'b10: gnt_c = 2'b10;
      2'b11: begin
        if (!tie_q) begin
          gnt_c = old1_q ? 2'b10 : 2'b01;
        end else if (s0.addr == s1.addr) begin
          gnt_c = 2'b01;
        end else begin
          gnt_c     = rr_q ? 2'b10 : 2'b01;
          rr_flip_c = 1'b1;
        end
      end
      default: gnt_c = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tie_q         <= 1'b0;
      old1_q        <= 1'b0;
      rr_q          <= 1'b0;
      rf_RegWrite   <= 1'b0;
      rf_RD_Address <= '0;
      rf_RDdata     <= '0;
    end else begin
      rr_q <= rr_q ^ rr_flip_c;
      // A lone load is younger than whatever the other slot still holds.
      if (load0_c && load1_c) begin
        tie_q <= 1'b1;
      end else if (load0_c) begin
        tie_q  <= 1'b0;
        old1_q <= 1'b1;
      end else if (load1_c) begin
        tie_q  <= 1'b0;
        old1_q <= 1'b0;
      end
      rf_RegWrite <= |gnt_c;
      if (|gnt_c) begin
        rf_RD_Address <= gnt_c[1] ? s1.addr : s0.addr;
        rf_RDdata     <= gnt_c[1] ? s1.data : s0.data;
      end
    end
  end

  always_comb begin
    rs_pending = (rs_addr != REG_ZERO) &&
                 ((s0.full && (s0.addr == rs_addr)) ||
                  (s1.full && (s1.addr == rs_addr)) ||
                  (rf_RegWrite && (rf_RD_Address == rs_addr)));
    rt_pending = (rt_addr != REG_ZERO) &&
                 ((s0.full && (s0.addr == rt_addr)) ||
                  (s1.full && (s1.addr == rt_addr)) ||
                  (rf_RegWrite && (rf_RD_Address == rt_addr)));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, corner sequences, random vs. model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          v[2];
  logic [AW-1:0] a[2];
  logic [DW-1:0] d[2];
  logic          rdy0, rdy1;
  logic          rf_RegWrite;
  logic [AW-1:0] rf_RD_Address;
  logic [DW-1:0] rf_RDdata;
  logic [AW-1:0] rs_addr, rt_addr;
  logic          rs_pending, rt_pending;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_addr(a[0]), .req0_data(d[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_addr(a[1]), .req1_data(d[1]),
    .rf_RegWrite(rf_RegWrite), .rf_RD_Address(rf_RD_Address), .rf_RDdata(rf_RDdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each slot is an entry stamped with its acceptance cycle.
  bit            mf[2];
  logic [AW-1:0] ma[2];
  logic [DW-1:0] md[2];
  int            ms[2];
  bit            mrr;
  bit            mwe;
  logic [AW-1:0] moa;
  logic [DW-1:0] mod;
  int            cyc;
  int            mg;
  bit            mflip;
  bit            mrdy[2];
  bit            macc[2];

  logic [DW-1:0] rf_mem[NUM_REGS];
  int            strobes = 0;
  bit            cyc_we;
  logic [AW-1:0] cyc_wa;

  typedef struct {
    bit v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [AW-1:0] rs; logic [AW-1:0] rt;
    bit we; logic [AW-1:0] oa; logic [DW-1:0] od;
    bit r0; bit r1; bit rsp; bit rtp;
  } vec_t;

  vec_t tv[11];
  vec_t cur;
  bit   tv_active = 1'b0;

  task automatic model_clear();
    for (int n = 0; n < 2; n++) begin
      mf[n] = 1'b0; ma[n] = '0; md[n] = '0; ms[n] = 0;
    end
    mrr = 1'b0; mwe = 1'b0; moa = '0; mod = '0;
  endtask

  function automatic bit m_pend(input logic [AW-1:0] x);
    return (x != 0) && ((mf[0] && ma[0] == x) || (mf[1] && ma[1] == x) || (mwe && moa == x));
  endfunction

  task automatic model_grant();
    mg = -1; mflip = 1'b0;
    if (mf[0] && !mf[1]) mg = 0;
    else if (mf[1] && !mf[0]) mg = 1;
    else if (mf[0] && mf[1]) begin
      if (ms[0] < ms[1]) mg = 0;
      else if (ms[1] < ms[0]) mg = 1;
      else if (ma[0] == ma[1]) mg = 0;
      else begin mg = mrr ? 1 : 0; mflip = 1'b1; end
    end
    mrdy[0] = !mf[0] || (mg == 0);
    mrdy[1] = !mf[1] || (mg == 1);
  endtask

  // One clock: compare at negedge, then advance model on the posedge.
  task automatic cycle();
    @(negedge clk);
    model_grant();
    chk("we", rf_RegWrite, mwe);
    chk("wr_addr", rf_RD_Address, moa);
    chk("wr_data", rf_RDdata, mod);
    chk("ready0", rdy0, mrdy[0]);
    chk("ready1", rdy1, mrdy[1]);
    chk("rs_pending", rs_pending, m_pend(rs_addr));
    chk("rt_pending", rt_pending, m_pend(rt_addr));
    if (tv_active) begin
      chk("tv_we", rf_RegWrite, cur.we);
      chk("tv_addr", rf_RD_Address, cur.oa);
      chk("tv_data", rf_RDdata, cur.od);
      chk("tv_ready0", rdy0, cur.r0);
      chk("tv_ready1", rdy1, cur.r1);
      chk("tv_rs_pending", rs_pending, cur.rsp);
      chk("tv_rt_pending", rt_pending, cur.rtp);
    end
    cyc_we = rf_RegWrite;
    cyc_wa = rf_RD_Address;
    if (rf_RegWrite === 1'b1) begin
      rf_mem[rf_RD_Address] = rf_RDdata;
      strobes++;
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) macc[n] = v[n] && mrdy[n] && !rst;
    if (rst) begin
      model_clear();
    end else begin
      if (mg >= 0) begin
        mwe = 1'b1; moa = ma[mg]; mod = md[mg]; mf[mg] = 1'b0;
      end else begin
        mwe = 1'b0;
      end
      if (mflip) mrr = !mrr;
      for (int n = 0; n < 2; n++) begin
        if (macc[n] && a[n] != 0) begin
          mf[n] = 1'b1; ma[n] = a[n]; md[n] = d[n]; ms[n] = cyc;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic apply(input vec_t t);
    v[0] = t.v0; a[0] = t.a0; d[0] = t.d0;
    v[1] = t.v1; a[1] = t.a1; d[1] = t.d1;
    rs_addr = t.rs; rt_addr = t.rt;
    cur = t; tv_active = 1'b1;
    cycle();
    tv_active = 1'b0;
  endtask

  task automatic idle();
    v[0] = 1'b0; v[1] = 1'b0; a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int str0, acc_cnt, gaps, alt_err, prev_cls;
    bit hold[2];
    bit prev_we;

    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    //           v0 a0  d0         v1 a1  d1          rs  rt   we oa  od        r0 r1 rsp rtp
    tv[0]  = '{1, 5, 32'h1234,  0, 0, 32'h0,     5,  0,   0, 0, 32'h0,    1, 1, 0, 0};
    tv[1]  = '{0, 0, 32'h0,     0, 0, 32'h0,     5,  5,   0, 0, 32'h0,    1, 1, 1, 1};
    tv[2]  = '{0, 0, 32'h0,     0, 0, 32'h0,     5,  0,   1, 5, 32'h1234, 1, 1, 1, 0};
    tv[3]  = '{0, 0, 32'h0,     0, 0, 32'h0,     5,  0,   0, 5, 32'h1234, 1, 1, 0, 0};
    tv[4]  = '{1, 3, 32'hA,     1, 3, 32'hB,     3,  5,   0, 5, 32'h1234, 1, 1, 0, 0};
    tv[5]  = '{0, 0, 32'h0,     0, 0, 32'h0,     3,  5,   0, 5, 32'h1234, 1, 0, 1, 0};
    tv[6]  = '{0, 0, 32'h0,     0, 0, 32'h0,     3,  5,   1, 3, 32'hA,    1, 1, 1, 0};
    tv[7]  = '{0, 0, 32'h0,     0, 0, 32'h0,     3,  5,   1, 3, 32'hB,    1, 1, 1, 0};
    tv[8]  = '{0, 0, 32'h0,     1, 0, 32'hFFFF,  0,  0,   0, 3, 32'hB,    1, 1, 0, 0};
    tv[9]  = '{0, 0, 32'h0,     0, 0, 32'h0,     0,  0,   0, 3, 32'hB,    1, 1, 0, 0};
    tv[10] = '{0, 0, 32'h0,     0, 0, 32'h0,     0,  3,   0, 3, 32'hB,    1, 1, 0, 0};

    idle();
    rs_addr = '0; rt_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cyc = 0;

    // Reset state, pending low for every address.
    chk("reset_we", rf_RegWrite, 1'b0);
    chk("reset_addr", rf_RD_Address, '0);
    chk("reset_data", rf_RDdata, '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      rs_addr = AW'(i); rt_addr = AW'(NUM_REGS - 1 - i);
      cycle();
    end

    // Single write latency, same-address ordering, address-zero drop.
    for (int i = 0; i < 11; i++) apply(tv[i]);
    chk("r3_final", rf_mem[3], 32'hB);

    // Reset while both slots are full.
    v[0] = 1'b1; a[0] = 5'd7; d[0] = 32'h1;
    v[1] = 1'b1; a[1] = 5'd8; d[1] = 32'h2;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_we_after_rst", rf_RegWrite, 1'b0);
    chk("t6_ready0", rdy0, 1'b1);
    chk("t6_ready1", rdy1, 1'b1);
    str0 = strobes;
    repeat (5) cycle();
    chk("t6_no_stale_write", strobes - str0, 0);

    // Both requesters saturated with distinct address ranges.
    str0 = strobes; acc_cnt = 0; gaps = 0; alt_err = 0; prev_cls = -1; prev_we = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          v[n] = 1'b1;
          a[n] = (n == 0) ? AW'($urandom_range(1, 15)) : AW'($urandom_range(16, 31));
          d[n] = $urandom;
          hold[n] = 1'b1;
        end
      end
      cycle();
      for (int n = 0; n < 2; n++) if (macc[n]) begin acc_cnt++; hold[n] = 1'b0; end
      if (it >= 2 && !cyc_we) gaps++;
      if (cyc_we) begin
        if (prev_we && prev_cls == int'(cyc_wa >= 16)) alt_err++;
        prev_cls = int'(cyc_wa >= 16);
      end
      prev_we = cyc_we;
    end
    idle();
    repeat (4) cycle();
    chk("t4_strobe_every_cycle", gaps, 0);
    chk("t4_grants_alternate", alt_err, 0);
    chk("t4_no_loss_or_dup", strobes - str0, acc_cnt);

    // Random traffic with colliding addresses and sporadic resets.
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          v[n] = ($urandom_range(0, 9) < 6);
          a[n] = AW'($urandom_range(0, 3));
          d[n] = $urandom;
          hold[n] = v[n];
        end
      end
      rs_addr = AW'($urandom_range(0, 3));
      rt_addr = AW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      for (int n = 0; n < 2; n++) if (macc[n]) hold[n] = 1'b0;
    end
    rst = 1'b0;
    idle();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
